// File: rtl/adder_pkg.sv
// Shared constants for the chunked pipelined adder.
// WIDTH_DEF / CHUNK_DEF : default operand width and bits summed per stage.
// stages_of()           : number of pipeline stages for a given width/chunk.
package adder_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CHUNK_DEF = 4;

  // Guarded against CHUNK=0 so elaboration reaches the explicit config check
  // in the top instead of dying on a divide-by-zero.
  function automatic int stages_of(input int width, input int chunk);
    return (chunk > 0) ? (width / chunk) : 1;
  endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One registered CHUNK-bit slice of the pipelined adder.
// Stage IDX adds bits [IDX*CHUNK +: CHUNK] of the operands plus the carry from
// the previous stage. The full operands and the partial sum travel with the token.
// Ports:
//   clk, rst            clock, synchronous active-high reset (valid bit only)
//   adv                 pipeline advance enable; all registers hold when low
//   tok_*               token entering this stage
//   res_*               registered token leaving this stage
module adder_pipe_stage
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             tok_vld,
  input  logic [WIDTH-1:0] tok_a,
  input  logic [WIDTH-1:0] tok_b,
  input  logic [WIDTH-1:0] tok_sum,
  input  logic             tok_carry,
  output logic             res_vld,
  output logic [WIDTH-1:0] res_a,
  output logic [WIDTH-1:0] res_b,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_carry
);

  localparam int LO = IDX * CHUNK;

  logic [CHUNK:0]   part;
  logic [WIDTH-1:0] sum_nxt;

  always_comb begin
    part    = {1'b0, tok_a[LO +: CHUNK]} + {1'b0, tok_b[LO +: CHUNK]}
            + {{CHUNK{1'b0}}, tok_carry};
    sum_nxt = tok_sum;
    sum_nxt[LO +: CHUNK] = part[CHUNK-1:0];
  end

  // ---- stage register boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      res_vld <= 1'b0;
    end else if (adv) begin
      res_vld <= tok_vld;
    end
  end

  // Data path carries no reset; the valid bit alone qualifies it.
  always_ff @(posedge clk) begin
    if (adv) begin
      res_a     <= tok_a;
      res_b     <= tok_b;
      res_sum   <= sum_nxt;
      res_carry <= part[CHUNK];
    end
  end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined ripple adder: WIDTH-bit sum computed CHUNK bits per stage with a
// valid/ready handshake. A token accepted at edge N is presented after edge
// N+STAGES-1; the whole pipe stalls together when the output is blocked.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   i_valid / o_ready    upstream handshake (o_ready is the advance enable)
//   i_a, i_b, i_carry    operands and carry-in
//   o_valid / i_ready    downstream handshake
//   o_sum, o_carry       (a + b + carry) mod 2^WIDTH and carry out
//   o_overflow           two's-complement overflow of the sum
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_overflow
);

  localparam int STAGES = stages_of(WIDTH, CHUNK);

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("adder_pipe: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)",
           WIDTH, CHUNK);
  end

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // Index 0 is the incoming token; index k+1 is the register of stage k.
  logic             vld_p   [STAGES+1];
  logic [WIDTH-1:0] a_p     [STAGES+1];
  logic [WIDTH-1:0] b_p     [STAGES+1];
  logic [WIDTH-1:0] sum_p   [STAGES+1];
  logic             carry_p [STAGES+1];
  logic             adv;

  // Depends only on registered state and i_ready, never on i_valid.
  assign adv     = !o_valid || i_ready;
  assign o_ready = adv;

  assign vld_p[0]   = i_valid;
  assign a_p[0]     = i_a;
  assign b_p[0]     = i_b;
  assign sum_p[0]   = '0;
  assign carry_p[0] = i_carry;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_pipe_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .adv       (adv),
      .tok_vld   (vld_p[k]),
      .tok_a     (a_p[k]),
      .tok_b     (b_p[k]),
      .tok_sum   (sum_p[k]),
      .tok_carry (carry_p[k]),
      .res_vld   (vld_p[k+1]),
      .res_a     (a_p[k+1]),
      .res_b     (b_p[k+1]),
      .res_sum   (sum_p[k+1]),
      .res_carry (carry_p[k+1])
    );
  end

  // ---- output boundary ----
  // Outputs are forced to zero without a valid token, which also gives the
  // all-zero result after reset without resetting the data registers.
  assign o_valid    = vld_p[STAGES];
  assign o_sum      = o_valid ? sum_p[STAGES] : '0;
  assign o_carry    = o_valid & carry_p[STAGES];
  assign o_overflow = o_valid & signed_ovf(a_p[STAGES][WIDTH-1],
                                           b_p[STAGES][WIDTH-1],
                                           sum_p[STAGES][WIDTH-1]);

endmodule

// File: tb/tb_adder_pipe.sv
module tb_adder_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid, o_ready, i_carry, o_valid, i_ready, o_carry, o_overflow;
  logic [7:0] i_a, i_b, o_sum;

  logic       v1, r1, c1, ov1, rd1, co1, of1;
  logic [7:0] a1, b1, s1;

  always #5 clk = ~clk;

  adder_pipe #(.WIDTH(8), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_carry(i_carry), .o_valid(o_valid),
    .i_ready(i_ready), .o_sum(o_sum), .o_carry(o_carry), .o_overflow(o_overflow)
  );

  adder_pipe #(.WIDTH(8), .CHUNK(8)) dut1 (
    .clk(clk), .rst(rst), .i_valid(v1), .o_ready(r1),
    .i_a(a1), .i_b(b1), .i_carry(c1), .o_valid(ov1),
    .i_ready(rd1), .o_sum(s1), .o_carry(co1), .o_overflow(of1)
  );

  typedef struct packed { logic [7:0] s; logic c; logic v; } res_t;
  typedef struct { logic [7:0] a; logic [7:0] b; logic ci;
                   logic [7:0] s; logic co; logic ov; } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_out   = 0;
  res_t sb[$];
  logic hold_chk = 1'b0;
  res_t hold_val;

  // Reference: plain integer arithmetic on the unsigned and signed views.
  function automatic res_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic ci);
    int unsigned u;
    int          s;
    res_t        r;
    u   = int'(a) + int'(b) + int'(ci);
    s   = int'($signed(a)) + int'($signed(b)) + int'(ci);
    r.s = 8'(u % 256);
    r.c = (u > 255);
    r.v = (s > 127) || (s < -128);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One handshake cycle on the CHUNK=4 instance with scoreboard checking.
  task automatic cyc(input logic v, input logic [7:0] a, input logic [7:0] b,
                     input logic ci, input logic rdy, output logic acc);
    res_t e;
    i_valid = v; i_a = a; i_b = b; i_carry = ci; i_ready = rdy;
    #1;
    chk("ready_rule", 32'(o_ready), 32'(!o_valid || rdy));
    if (hold_chk) begin
      chk("hold_valid", 32'(o_valid), 32'(1));
      chk("hold_out", 32'({o_sum, o_carry, o_overflow}), 32'(hold_val));
    end
    acc = v && o_ready;
    if (o_valid && rdy) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_out", 32'({o_sum, o_carry, o_overflow}), 32'(e));
        n_out++;
      end
    end
    hold_chk = o_valid && !rdy;
    hold_val = '{s: o_sum, c: o_carry, v: o_overflow};
    @(posedge clk); #1;
    if (acc) sb.push_back(model(a, b, ci));
  endtask

  task automatic drain(input string name);
    logic acc;
    int   t;
    t = 0;
    while (sb.size() != 0 && t < 40) begin
      cyc(1'b0, 8'($urandom()), 8'($urandom()), 1'($urandom()), 1'b1, acc);
      t++;
    end
    chk(name, 32'(sb.size()), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       tbl[8];
    logic [7:0] sa[16], sbv[16];
    logic       sc[16];
    logic       acc, bad;
    int         accepted, t, out0;
    res_t       e;

    tbl[0] = '{a:8'hFF, b:8'h01, ci:1'b0, s:8'h00, co:1'b1, ov:1'b0};
    tbl[1] = '{a:8'h7F, b:8'h01, ci:1'b0, s:8'h80, co:1'b0, ov:1'b1};
    tbl[2] = '{a:8'h80, b:8'h80, ci:1'b0, s:8'h00, co:1'b1, ov:1'b1};
    tbl[3] = '{a:8'h00, b:8'h00, ci:1'b1, s:8'h01, co:1'b0, ov:1'b0};
    tbl[4] = '{a:8'h12, b:8'h34, ci:1'b1, s:8'h47, co:1'b0, ov:1'b0};
    tbl[5] = '{a:8'hFF, b:8'hFF, ci:1'b1, s:8'hFF, co:1'b1, ov:1'b0};
    tbl[6] = '{a:8'h40, b:8'h40, ci:1'b0, s:8'h80, co:1'b0, ov:1'b1};
    tbl[7] = '{a:8'h0F, b:8'h01, ci:1'b0, s:8'h10, co:1'b0, ov:1'b0};

    rst = 1'b1; i_valid = 1'b0; i_a = '0; i_b = '0; i_carry = 1'b0; i_ready = 1'b1;
    v1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0; rd1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(o_valid), 32'(0));
    chk("rst_out", 32'({o_sum, o_carry, o_overflow}), 32'(0));
    chk("rst_ready", 32'(o_ready), 32'(1));
    chk("rst_valid1", 32'(ov1), 32'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors: latency of two edges, then the result.
    for (int i = 0; i < 8; i++) begin
      i_valid = 1'b1; i_a = tbl[i].a; i_b = tbl[i].b; i_carry = tbl[i].ci; i_ready = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      chk($sformatf("vec%0d_early", i), 32'(o_valid), 32'(0));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), 32'(o_valid), 32'(1));
      chk($sformatf("vec%0d_sum", i), 32'(o_sum), 32'(tbl[i].s));
      chk($sformatf("vec%0d_carry", i), 32'(o_carry), 32'(tbl[i].co));
      chk($sformatf("vec%0d_ovf", i), 32'(o_overflow), 32'(tbl[i].ov));
    end
    @(posedge clk); #1;

    // 16 back-to-back tokens: results on 16 consecutive cycles.
    for (int i = 0; i < 16; i++) begin
      sa[i] = 8'($urandom()); sbv[i] = 8'($urandom()); sc[i] = 1'($urandom());
    end
    for (int c = 0; c < 19; c++) begin
      i_ready = 1'b1;
      i_valid = (c < 16);
      if (c < 16) begin i_a = sa[c]; i_b = sbv[c]; i_carry = sc[c]; end
      #1;
      if (c >= 2 && c < 18) begin
        e = model(sa[c-2], sbv[c-2], sc[c-2]);
        chk($sformatf("stream%0d_valid", c-2), 32'(o_valid), 32'(1));
        chk($sformatf("stream%0d_out", c-2), 32'({o_sum, o_carry, o_overflow}), 32'(e));
      end else begin
        chk($sformatf("stream_idle%0d", c), 32'(o_valid), 32'(0));
      end
      @(posedge clk); #1;
    end
    i_valid = 1'b0;

    // Four tokens with a three-cycle downstream stall mid-stream.
    accepted = 0; t = 0; out0 = n_out;
    while (accepted < 4 && t < 40) begin
      cyc(1'b1, 8'($urandom()), 8'($urandom()), 1'($urandom()),
          !(t >= 2 && t < 5), acc);
      if (acc) accepted++;
      t++;
    end
    chk("stall_accepted", 32'(accepted), 32'(4));
    drain("stall_drain");
    chk("stall_count", 32'(n_out - out0), 32'(4));

    // Randomized valid/ready traffic against the scoreboard.
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 8'($urandom()), 8'($urandom()),
          1'($urandom()), 1'($urandom_range(0, 3) != 0), acc);
    end
    drain("rand_drain");

    // Reset with two tokens held in a stalled pipe, plus an accept during reset.
    hold_chk = 1'b0;
    i_ready = 1'b0;
    i_valid = 1'b1; i_a = 8'h11; i_b = 8'h22; i_carry = 1'b0;
    @(posedge clk); #1;
    i_a = 8'h33; i_b = 8'h44;
    @(posedge clk); #1;
    chk("pre_rst_stalled", 32'(o_ready), 32'(0));
    rst = 1'b1; i_a = 8'h55; i_b = 8'h66;
    @(posedge clk); #1;
    chk("mid_rst_valid", 32'(o_valid), 32'(0));
    chk("mid_rst_out", 32'({o_sum, o_carry, o_overflow}), 32'(0));
    chk("mid_rst_ready", 32'(o_ready), 32'(1));
    rst = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (o_valid) bad = 1'b1;
    end
    chk("post_rst_no_result", 32'(bad), 32'(0));

    // Single-stage instance: registered adder, result after the accept edge.
    v1 = 1'b1; a1 = 8'h10; b1 = 8'h20; c1 = 1'b1; rd1 = 1'b1;
    #1;
    chk("s1_pre_valid", 32'(ov1), 32'(0));
    @(posedge clk); #1;
    v1 = 1'b0;
    chk("s1_valid", 32'(ov1), 32'(1));
    chk("s1_sum", 32'(s1), 32'(8'h31));
    chk("s1_carry_ovf", 32'({co1, of1}), 32'(0));
    v1 = 1'b1; a1 = 8'hF0; b1 = 8'h20; c1 = 1'b0; rd1 = 1'b0;
    @(posedge clk); #1;
    chk("s1_stall_ready", 32'(r1), 32'(0));
    chk("s1_hold_sum", 32'(s1), 32'(8'h31));
    rd1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    chk("s1_next", 32'({s1, co1, of1}), 32'(model(8'hF0, 8'h20, 1'b0)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_pipe.md
ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand and sum width in bits (>= 1).
REQ-002 Parameter CHUNK, default 4, bits added per pipeline stage; WIDTH SHALL be an integer multiple of CHUNK; STAGES = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 i_valid  input  1  upstream operands valid.
REQ-006 o_ready  output  1  block can accept operands this cycle.
REQ-007 i_a  input  WIDTH  operand A, unsigned/two's-complement.
REQ-008 i_b  input  WIDTH  operand B.
REQ-009 i_carry  input  1  carry-in to bit 0.
REQ-010 o_valid  output  1  result valid.
REQ-011 i_ready  input  1  downstream accepts result.
REQ-012 o_sum  output  WIDTH  (i_a + i_b + i_carry) mod 2^WIDTH.
REQ-013 o_carry  output  1  carry out of bit WIDTH-1.
REQ-014 o_overflow  output  1  signed overflow: operand MSBs equal and differ from o_sum MSB.

Function
REQ-015 Accept when i_valid && o_ready on a rising edge; transfer out when o_valid && i_ready.
REQ-016 Stage k (0..STAGES-1) adds chunk k of A and B plus carry from stage k-1 (stage 0 uses i_carry); lower chunks already summed and upper unsummed operand chunks travel with the token.
REQ-017 Pipeline advance enable adv = !o_valid || i_ready; all stages shift together when adv=1, hold all contents when adv=0.
REQ-018 o_ready SHALL equal adv (combinational; no combinational path from i_valid to o_ready).
REQ-019 Latency: a token accepted at edge N SHALL appear on o_valid/o_sum after edge N+STAGES-1 when no stall occurs; each stall cycle adds one cycle.
REQ-020 Throughput: one result per cycle when i_valid and i_ready are held high.
REQ-021 Cycles with no accept insert a bubble (valid=0) which advances like a token; bubbles are not collapsed.
REQ-022 While o_valid=1 and i_ready=0, o_sum, o_carry, o_overflow SHALL hold stable.
REQ-023 STAGES=1 SHALL degenerate to a single registered adder with identical handshake.
REQ-024 Operand values presented with i_valid=0 SHALL have no effect on any output.

Reset
REQ-025 rst=1 at an edge SHALL clear every stage valid bit; o_valid=0 the following cycle; o_sum, o_carry, o_overflow = 0.
REQ-026 rst mid-operation SHALL discard all in-flight tokens; no partial result emerges after reset.
REQ-027 o_ready SHALL be 1 during and after reset (o_valid=0 implies adv=1); an accept coinciding with rst=1 is discarded.

Structure
REQ-028 Package adder_pkg SHALL hold default WIDTH/CHUNK constants and the STAGES derivation function.
REQ-029 Sub-module adder_pipe_stage (one registered CHUNK-bit add stage with valid bit and adv enable) SHALL be instantiated STAGES times by generate.
REQ-030 An elaboration-time check SHALL fail if WIDTH mod CHUNK != 0.

Verification (WIDTH=8, CHUNK=4 unless stated)
REQ-031 0xFF + 0x01, carry 0, i_ready=1 -> o_valid 2 cycles after accept edge... i.e. after edge N+1, o_sum=0x00, o_carry=1, o_overflow=0.
REQ-032 0x7F + 0x01 -> o_sum=0x80, o_carry=0, o_overflow=1; 0x80 + 0x80 -> 0x00, carry 1, overflow 1.
REQ-033 Stream 16 random pairs back-to-back, i_ready=1 -> 16 results in order on 16 consecutive cycles, each matching reference sum.
REQ-034 Stream 4 tokens with i_ready low for 3 cycles mid-stream -> o_ready=0 during stall, outputs stable, no loss/duplication, order preserved.
REQ-035 Assert rst while 2 tokens in flight -> o_valid=0 next cycle and no result from those tokens ever appears.
REQ-036 WIDTH=CHUNK=8: 0x10 + 0x20 + carry 1 -> o_sum=0x31 one edge after accept.
